// File: rtl/ddr3_pixel_reader_if.sv
// ddr3_pixel_reader_if
//   Bundles the Avalon-MM burst read port and the pixel output stream of
//   ddr3_pixel_reader.
//   master : the reader (drives read requests, sources pixels)
//   slave  : the memory controller / pixel sink side
//   Signals:
//     ddr3_read_address  word address (32-byte words)
//     ddr3_read          read request
//     ddr3_burstcount    words in the burst
//     ddr3_waitrequest   Avalon stall
//     ddr3_readdata      256-bit return data
//     ddr3_readdatavalid return data valid
//     pixel_data/valid/ready/eof  16-bit pixel stream, eof on last pixel
interface ddr3_pixel_reader_if #(
  parameter int burst_log = 1
);
  logic [26:0]        ddr3_read_address;
  logic               ddr3_read;
  logic [burst_log:0] ddr3_burstcount;
  logic               ddr3_waitrequest;
  logic [255:0]       ddr3_readdata;
  logic               ddr3_readdatavalid;
  logic [15:0]        pixel_data;
  logic               pixel_valid;
  logic               pixel_ready;
  logic               pixel_eof;

  modport master (
    output ddr3_read_address, ddr3_read, ddr3_burstcount,
    output pixel_data, pixel_valid, pixel_eof,
    input  ddr3_waitrequest, ddr3_readdata, ddr3_readdatavalid,
    input  pixel_ready
  );

  modport slave (
    input  ddr3_read_address, ddr3_read, ddr3_burstcount,
    input  pixel_data, pixel_valid, pixel_eof,
    output ddr3_waitrequest, ddr3_readdata, ddr3_readdatavalid,
    output pixel_ready
  );
endinterface

// File: rtl/ddr3_pixel_reader.sv
// ddr3_pixel_reader
//   Reads one frame of 16-bit pixels from DDR3 with Avalon-MM burst reads,
//   buffers the 256-bit words in a FIFO and unpacks each word into 16 pixels
//   (first pixel in bits [15:0]).
//   Ports:
//     ddr3_clk         sole clock
//     ddr3clk_reset    asynchronous active-high reset
//     start_address_i  frame byte address, [31:5] is the word address
//     frame_start      one-cycle pulse, starts a frame when idle
//     busy             frame in progress
//     bus              ddr3_pixel_reader_if.master (Avalon read + pixel stream)
//   Optional macro DDR3_PIXEL_READER_STATS_EN adds stall_count and
//   underrun_count (saturating, cleared by reset and an accepted frame_start).
//
// state          | meaning
// ST_IDLE        | waiting for frame_start
// ST_ISSUE       | waiting for FIFO credit to request the next burst
// ST_WAIT_ACCEPT | ddr3_read asserted, held until waitrequest drops
// ST_DRAIN       | all bursts issued, waiting for the last pixel
module ddr3_pixel_reader #(
  parameter int words_per_line = 60,
  parameter int lines          = 1920,
  parameter int burst_log      = 1,
  parameter int fifo_log       = 6
) (
  input  logic        ddr3_clk,
  input  logic        ddr3clk_reset,
  input  logic [31:0] start_address_i,
  input  logic        frame_start,
  output logic        busy,
`ifdef DDR3_PIXEL_READER_STATS_EN
  output logic [31:0] stall_count,
  output logic [31:0] underrun_count,
`endif
  ddr3_pixel_reader_if.master bus
);

  localparam int TOTAL = words_per_line * lines;
  localparam int TW_W  = $clog2(TOTAL + 1);
  localparam int DEPTH = 1 << fifo_log;
  localparam int MAXB  = 1 << burst_log;
  localparam int CW    = fifo_log + 1;
  localparam int BL_W  = burst_log + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT_ACCEPT, ST_DRAIN} state_t;
  state_t state, state_n;

  logic [26:0]      word_addr;
  logic [TW_W-1:0]  issued, popped, remaining;
  logic [CW-1:0]    outstanding, fifo_count;
  logic [fifo_log-1:0] wr_ptr, rd_ptr;
  logic [255:0]     fifo_mem [DEPTH];
  logic [255:0]     head_word;
  logic [3:0]       idx;
  logic [BL_W-1:0]  blen;
  logic [CW+1:0]    credit_sum;
  logic             credit_ok, frame_go, accept, rdv_take, pix_fire, pop;
  logic             last_word, last_issue;
  logic             addr_low_unused;

  assign addr_low_unused = ^start_address_i[4:0];

  assign remaining = TW_W'(TOTAL) - issued;
  assign blen = (remaining >= TW_W'(MAXB)) ? BL_W'(MAXB) : BL_W'(remaining);
  // Credit counts words already buffered plus words still in flight, so a
  // granted burst always has room in the FIFO when it returns.
  assign credit_sum = (CW+2)'(fifo_count) + (CW+2)'(outstanding) + (CW+2)'(blen);
  assign credit_ok  = credit_sum <= (CW+2)'(DEPTH);

  assign frame_go   = (state == ST_IDLE) && frame_start;
  assign accept     = (state == ST_WAIT_ACCEPT) && !bus.ddr3_waitrequest;
  // Returns with nothing outstanding are stale (e.g. from an aborted frame).
  assign rdv_take   = bus.ddr3_readdatavalid && (outstanding != '0);
  assign pix_fire   = bus.pixel_valid && bus.pixel_ready;
  assign pop        = pix_fire && (idx == 4'd15);
  assign last_word  = (popped == TW_W'(TOTAL - 1));
  assign last_issue = ((issued + TW_W'(blen)) == TW_W'(TOTAL));

  // FIFO head feeds the unpacker directly, so a pop exposes the next word
  // in the same cycle without a bubble.
  assign head_word       = fifo_mem[rd_ptr];
  assign bus.pixel_valid = (fifo_count != '0);
  assign bus.pixel_data  = bus.pixel_valid ? head_word[{idx, 4'b0000} +: 16] : 16'h0000;
  assign bus.pixel_eof   = bus.pixel_valid && (idx == 4'd15) && last_word;

  always_ff @(posedge ddr3_clk or posedge ddr3clk_reset) begin
    if (ddr3clk_reset) state <= ST_IDLE;
    else               state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:        if (frame_start) state_n = ST_ISSUE;
      ST_ISSUE:       if (credit_ok) state_n = ST_WAIT_ACCEPT;
      ST_WAIT_ACCEPT: if (accept) state_n = last_issue ? ST_DRAIN : ST_ISSUE;
      ST_DRAIN:       if (outstanding == '0 && fifo_count == CW'(1) && pop && last_word)
                        state_n = ST_IDLE;
      default:        state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.ddr3_read         = 1'b0;
    bus.ddr3_read_address = 27'd0;
    bus.ddr3_burstcount   = '0;
    busy                  = (state != ST_IDLE);
    if (state == ST_WAIT_ACCEPT) begin
      bus.ddr3_read         = 1'b1;
      bus.ddr3_read_address = word_addr;
      bus.ddr3_burstcount   = blen;
    end
  end

  always_ff @(posedge ddr3_clk or posedge ddr3clk_reset) begin
    if (ddr3clk_reset) begin
      word_addr   <= '0;
      issued      <= '0;
      popped      <= '0;
      outstanding <= '0;
      fifo_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      idx         <= '0;
    end else begin
      if (frame_go) begin
        word_addr <= start_address_i[31:5];
        issued    <= '0;
        popped    <= '0;
      end else begin
        if (accept) begin
          word_addr <= word_addr + 27'(blen);
          issued    <= issued + TW_W'(blen);
        end
        if (pop) popped <= popped + TW_W'(1);
      end
      outstanding <= outstanding + (accept ? CW'(blen) : CW'(0)) - CW'(rdv_take);
      fifo_count  <= fifo_count + CW'(rdv_take) - CW'(pop);
      if (rdv_take) wr_ptr <= wr_ptr + 1'b1;
      if (pop)      rd_ptr <= rd_ptr + 1'b1;
      if (pix_fire) idx    <= idx + 4'd1;
    end
  end

  always_ff @(posedge ddr3_clk) begin
    if (rdv_take) fifo_mem[wr_ptr] <= bus.ddr3_readdata;
  end

`ifdef DDR3_PIXEL_READER_STATS_EN
  always_ff @(posedge ddr3_clk or posedge ddr3clk_reset) begin
    if (ddr3clk_reset) begin
      stall_count    <= '0;
      underrun_count <= '0;
    end else if (frame_go) begin
      stall_count    <= '0;
      underrun_count <= '0;
    end else begin
      if (bus.ddr3_read && bus.ddr3_waitrequest && stall_count != '1)
        stall_count <= stall_count + 32'd1;
      if (busy && bus.pixel_ready && !bus.pixel_valid && underrun_count != '1)
        underrun_count <= underrun_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ddr3_pixel_reader.sv
`timescale 1ns/1ps
module tb_ddr3_pixel_reader;
  localparam int WPL   = 3;
  localparam int LINES = 3;
  localparam int BLOG  = 1;
  localparam int FLOG  = 3;
  localparam int TOTAL = WPL * LINES;
  localparam int DEPTH = 1 << FLOG;
  localparam int MAXB  = 1 << BLOG;

  logic        ddr3_clk = 1'b0;
  logic        ddr3clk_reset = 1'b1;
  logic [31:0] start_address_i = 32'd0;
  logic        frame_start = 1'b0;
  logic        busy;
`ifdef DDR3_PIXEL_READER_STATS_EN
  logic [31:0] stall_count, underrun_count;
`endif

  ddr3_pixel_reader_if #(.burst_log(BLOG)) bus();

  ddr3_pixel_reader #(
    .words_per_line(WPL), .lines(LINES), .burst_log(BLOG), .fifo_log(FLOG)
  ) dut (
    .ddr3_clk(ddr3_clk),
    .ddr3clk_reset(ddr3clk_reset),
    .start_address_i(start_address_i),
    .frame_start(frame_start),
    .busy(busy),
`ifdef DDR3_PIXEL_READER_STATS_EN
    .stall_count(stall_count),
    .underrun_count(underrun_count),
`endif
    .bus(bus)
  );

  always #5 ddr3_clk = ~ddr3_clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // memory / sink model state
  typedef struct { int due; logic [255:0] data; } ret_t;
  ret_t         retq[$];
  logic [26:0]  req_addr_q[$];
  int           req_len_q[$];
  logic [15:0]  exp_pix_q[$];
  logic [31:0]  seed;
  int cyc = 0, lat = 5, stall_left = 0, ready_mode = 0;
  int acc_words = 0, pix_acc = 0, n_acc = 0, n_eof = 0, n_req_exp = 0, last_due = 0;
  bit prev_accept = 0, hold_valid = 0;
  logic [15:0] hold_data;

  function automatic logic [255:0] mem_word(input logic [26:0] a);
    logic [255:0] w;
    for (int k = 0; k < 8; k++)
      w[32*k +: 32] = ({5'b0, a} * 32'h9E3779B1) ^ (32'(k) * 32'h7F4A7C15) ^ seed;
    return w;
  endfunction

  // Reference: the whole frame as a list of bursts and a list of pixels.
  task automatic plan_frame(input logic [31:0] sa);
    logic [26:0]  base;
    logic [255:0] w;
    base = sa[31:5];
    req_addr_q.delete(); req_len_q.delete(); exp_pix_q.delete();
    for (int i = 0; i < TOTAL; i += MAXB) begin
      req_addr_q.push_back(base + 27'(i));
      req_len_q.push_back((TOTAL - i < MAXB) ? TOTAL - i : MAXB);
    end
    for (int i = 0; i < TOTAL; i++) begin
      w = mem_word(base + 27'(i));
      for (int p = 0; p < 16; p++) exp_pix_q.push_back(w[16*p +: 16]);
    end
    n_req_exp = req_addr_q.size();
    acc_words = 0; pix_acc = 0; n_acc = 0; n_eof = 0;
  endtask

  // Avalon slave + pixel sink, acting on the falling edge.
  initial begin
    forever begin
      logic [26:0] a;
      int d;
      bit r, acc_now;
      @(negedge ddr3_clk);
      cyc++;
      acc_now = 0;
      bus.ddr3_waitrequest = 1'b0;
      if (prev_accept) chk("req_gap", bus.ddr3_read, 1'b0);
      if (bus.ddr3_read) begin
        a = bus.ddr3_read_address;
        if (req_addr_q.size() == 0) chk("extra_req", bus.ddr3_read, 1'b0);
        else begin
          chk("req_addr", a, req_addr_q[0]);
          chk("req_len", bus.ddr3_burstcount, req_len_q[0]);
          if (stall_left > 0) begin
            stall_left--;
            bus.ddr3_waitrequest = 1'b1;
          end else begin
            for (int k = 0; k < int'(bus.ddr3_burstcount); k++) begin
              d = cyc + lat + k;
              if (d <= last_due) d = last_due + 1;
              last_due = d;
              retq.push_back('{d, mem_word(a + 27'(k))});
            end
            acc_words += int'(bus.ddr3_burstcount);
            n_acc++;
            acc_now = 1;
            void'(req_addr_q.pop_front());
            void'(req_len_q.pop_front());
          end
        end
      end
      prev_accept = acc_now;

      bus.ddr3_readdatavalid = 1'b0;
      bus.ddr3_readdata = '0;
      if (retq.size() > 0 && retq[0].due <= cyc) begin
        bus.ddr3_readdatavalid = 1'b1;
        bus.ddr3_readdata = retq[0].data;
        void'(retq.pop_front());
      end

      if (hold_valid) begin
        chk("hold_valid", bus.pixel_valid, 1'b1);
        chk("hold_data", bus.pixel_data, hold_data);
      end
      case (ready_mode)
        0: r = 1;
        1: r = ($urandom_range(0, 3) != 0);
        default: r = 0;
      endcase
      bus.pixel_ready = r;
      if (bus.pixel_valid && r) begin
        if (exp_pix_q.size() == 0) chk("extra_pix", bus.pixel_valid, 1'b0);
        else begin
          chk("pix_data", bus.pixel_data, exp_pix_q[0]);
          chk("pix_eof", bus.pixel_eof, exp_pix_q.size() == 1);
          void'(exp_pix_q.pop_front());
        end
        pix_acc++;
        if (bus.pixel_eof) n_eof++;
      end
      hold_valid = bus.pixel_valid && !r;
      hold_data  = bus.pixel_data;
      if (busy) chk("credit", (acc_words - pix_acc / 16) <= DEPTH, 1'b1);
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge ddr3_clk); #2; end
  endtask

  task automatic start_frame(input logic [31:0] sa);
    seed = $urandom;
    plan_frame(sa);
    start_address_i = sa;
    frame_start = 1'b1;
    step(1);
    frame_start = 1'b0;
    start_address_i = $urandom;
    chk("busy_rise", busy, 1'b1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin step(1); n++; end
    chk({tag, "_busy_fall"}, busy, 1'b0);
    chk({tag, "_pixels"}, pix_acc, TOTAL * 16);
    chk({tag, "_eof_count"}, n_eof, 1);
    chk({tag, "_bursts"}, n_acc, n_req_exp);
    chk({tag, "_pix_left"}, exp_pix_q.size(), 0);
    step(2);
    chk({tag, "_idle_valid"}, bus.pixel_valid, 1'b0);
  endtask

  initial begin
    int n;
    bus.ddr3_waitrequest = 1'b0;
    bus.ddr3_readdata = '0;
    bus.ddr3_readdatavalid = 1'b0;
    bus.pixel_ready = 1'b0;
    seed = 32'h1234_5678;
    step(3);
    chk("rst_read", bus.ddr3_read, 1'b0);
    chk("rst_addr", bus.ddr3_read_address, 27'd0);
    chk("rst_len", bus.ddr3_burstcount, 2'd0);
    chk("rst_valid", bus.pixel_valid, 1'b0);
    chk("rst_eof", bus.pixel_eof, 1'b0);
    chk("rst_busy", busy, 1'b0);
`ifdef DDR3_PIXEL_READER_STATS_EN
    chk("rst_stall", stall_count, 32'd0);
`endif
    ddr3clk_reset = 1'b0;
    step(2);

    // plain frame at 0x1000: bursts from word 0x80, fixed latency 5
    lat = 5; ready_mode = 0; stall_left = 0;
    start_frame(32'h0000_1000);
    wait_done("basic", 1000);
`ifdef DDR3_PIXEL_READER_STATS_EN
    chk("basic_stall", stall_count, 32'd0);
    chk("basic_underrun", underrun_count >= 32'd5, 1'b1);
`endif

    // 7-cycle stall on first request, random sink, ignored restart
    lat = $urandom_range(1, 6); ready_mode = 1; stall_left = 7;
    start_frame($urandom & 32'hFFFF_FFE0);
    step(20);
    start_address_i = $urandom;
    frame_start = 1'b1;
    step(1);
    frame_start = 1'b0;
    wait_done("stall", 3000);
`ifdef DDR3_PIXEL_READER_STATS_EN
    chk("stall_count", stall_count, 32'd7);
`endif

    // sink blocked: requests must stop at the FIFO depth
    lat = $urandom_range(1, 6); ready_mode = 2;
    start_frame($urandom);
    step(2000);
    chk("credit_stop", acc_words, DEPTH);
    chk("credit_no_req", bus.ddr3_read, 1'b0);
    ready_mode = 1;
    wait_done("backpressure", 3000);

    // abort with two words outstanding, stale returns must vanish
    lat = 20; ready_mode = 0;
    start_frame($urandom);
    n = 0;
    while (acc_words < 2 && n < 50) begin step(1); n++; end
    chk("abort_outstanding", acc_words, 2);
    ddr3clk_reset = 1'b1;
    hold_valid = 0; prev_accept = 0;
    req_addr_q.delete(); req_len_q.delete(); exp_pix_q.delete();
    #1;
    chk("abort_read", bus.ddr3_read, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_valid", bus.pixel_valid, 1'b0);
    step(2);
    ddr3clk_reset = 1'b0;
    n = 0;
    while (retq.size() > 0 && n < 60) begin step(1); n++; end
    chk("stale_returned", retq.size(), 0);
    step(3);
    chk("stale_valid", bus.pixel_valid, 1'b0);
    chk("stale_busy", busy, 1'b0);

    lat = $urandom_range(1, 6); ready_mode = 1;
    start_frame($urandom);
    wait_done("after_abort", 3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
